// File: rtl/prism_comm_pkg.sv
// Shared types and constants for the PRISM COMM byte front end.
//   shift_state_e : shifter FSM states (ST_IDLE, ST_ACTIVE)
//   FIFO_DEPTH    : default entry count of the TX/RX byte FIFOs
//   BYTE_W        : width of one queued byte
package prism_comm_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } shift_state_e;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BYTE_W     = 8;

endpackage

// File: rtl/prism_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : write strobe and byte; accepted when not full, or when a pop frees a slot
//   pop         : discards the head entry; ignored when empty
//   flush       : synchronous clear, overrides push and pop
//   rdata       : head entry, 0 when empty
//   level       : entry count; full/empty status
//   drop        : one-cycle indication that a push was rejected because the FIFO was full
module prism_byte_fifo
    import prism_comm_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              do_push;
    logic              do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign drop    = push && !flush && full && !do_pop;

    assign rdata = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (!do_push && do_pop) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/prism_comm_fifo.sv
// PRISM COMM serial front end: TX byte queue -> bit shifter -> RX byte queue.
//   clk, rst_n            : clock, asynchronous active-low reset
//   tx_wdata, tx_push     : CPU transmit byte and queue strobe
//   rx_pop, rx_rdata      : CPU receive pop strobe and head byte (fall-through, 0 when empty)
//   tx_/rx_level/full/empty : queue status
//   flush, flag_clr       : clear queues+shifter / clear sticky flags
//   tx_ovf, rx_ovf, shift_unf : sticky error flags
//   shift_pulse, shift_dir, comm_in : PRISM shift strobe, bit order, serial input bit
//   bit_out, busy, byte_done : transmit bit, shifter active, one-cycle byte completion pulse
module prism_comm_fifo
    import prism_comm_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] tx_wdata,
    input  logic              tx_push,
    input  logic              rx_pop,
    output logic [BYTE_W-1:0] rx_rdata,
    output logic [LVL_W-1:0]  tx_level,
    output logic [LVL_W-1:0]  rx_level,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              rx_full,
    output logic              rx_empty,
    input  logic              flush,
    input  logic              flag_clr,
    output logic              tx_ovf,
    output logic              rx_ovf,
    output logic              shift_unf,
    input  logic              shift_pulse,
    input  logic              shift_dir,
    input  logic              comm_in,
    output logic              bit_out,
    output logic              busy,
    output logic              byte_done
);

    shift_state_e      state_q;
    logic [BYTE_W-1:0] sreg_q;
    logic [2:0]        bcnt_q;
    logic              byte_done_q;
    logic              tx_ovf_q;
    logic              rx_ovf_q;
    logic              shift_unf_q;

    logic [BYTE_W-1:0] tx_rdata;
    logic [BYTE_W-1:0] sreg_shifted;
    logic              shifting;
    logic              last_bit;
    logic              tx_pop;
    logic              rx_push;
    logic              tx_drop;
    logic              rx_drop;
    logic              unf_evt;

    assign sreg_shifted = shift_dir ? {comm_in, sreg_q[BYTE_W-1:1]}
                                    : {sreg_q[BYTE_W-2:0], comm_in};
    assign shifting = (state_q == ST_ACTIVE) && shift_pulse;
    assign last_bit = shifting && (bcnt_q == 3'd7);
    // Load from TX when idle, or back-to-back on the completing edge.
    assign tx_pop   = !flush && !tx_empty && ((state_q == ST_IDLE) || last_bit);
    assign rx_push  = !flush && last_bit;
    assign unf_evt  = shift_pulse && (state_q == ST_IDLE);

    prism_byte_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .wdata (tx_wdata),
        .rdata (tx_rdata),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty),
        .drop  (tx_drop)
    );

    prism_byte_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .wdata (sreg_shifted),
        .rdata (rx_rdata),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty),
        .drop  (rx_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bcnt_q      <= '0;
            byte_done_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bcnt_q      <= '0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= rx_push;
            if (tx_pop) begin
                state_q <= ST_ACTIVE;
                sreg_q  <= tx_rdata;
                bcnt_q  <= '0;
            end else if (last_bit) begin
                state_q <= ST_IDLE;
                sreg_q  <= sreg_shifted;
                bcnt_q  <= '0;
            end else if (shifting) begin
                sreg_q <= sreg_shifted;
                bcnt_q <= bcnt_q + 3'd1;
            end
        end
    end

    // A new error in the same cycle as flag_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            shift_unf_q <= 1'b0;
        end else begin
            tx_ovf_q    <= (tx_ovf_q & ~flag_clr) | tx_drop;
            rx_ovf_q    <= (rx_ovf_q & ~flag_clr) | rx_drop;
            shift_unf_q <= (shift_unf_q & ~flag_clr) | unf_evt;
        end
    end

    assign bit_out   = shift_dir ? sreg_q[0] : sreg_q[BYTE_W-1];
    assign busy      = (state_q == ST_ACTIVE);
    assign byte_done = byte_done_q;
    assign tx_ovf    = tx_ovf_q;
    assign rx_ovf    = rx_ovf_q;
    assign shift_unf = shift_unf_q;

endmodule

// File: tb/tb_prism_comm_fifo.sv
// Self-checking bench for prism_comm_fifo: expected RX bytes are queued as stimulus is
// driven and compared as the DUT presents them at rx_rdata.
module tb_prism_comm_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       tx_wdata;
    logic             tx_push;
    logic             rx_pop;
    logic [7:0]       rx_rdata;
    logic [LVL_W-1:0] tx_level;
    logic [LVL_W-1:0] rx_level;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             flush, flag_clr;
    logic             tx_ovf, rx_ovf, shift_unf;
    logic             shift_pulse, shift_dir;
    wire logic        comm_in;
    logic             comm_drv;
    logic             loop_en;
    logic             bit_out, busy, byte_done;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [7:0]       exp_q[$];

    always #5 clk = ~clk;

    // Loopback ties the serial input to the transmitted bit.
    assign comm_in = loop_en ? bit_out : comm_drv;

    prism_comm_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_wdata    (tx_wdata),
        .tx_push     (tx_push),
        .rx_pop      (rx_pop),
        .rx_rdata    (rx_rdata),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .rx_full     (rx_full),
        .rx_empty    (rx_empty),
        .flush       (flush),
        .flag_clr    (flag_clr),
        .tx_ovf      (tx_ovf),
        .rx_ovf      (rx_ovf),
        .shift_unf   (shift_unf),
        .shift_pulse (shift_pulse),
        .shift_dir   (shift_dir),
        .comm_in     (comm_in),
        .bit_out     (bit_out),
        .busy        (busy),
        .byte_done   (byte_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_wdata = b;
        tx_push  = 1'b1;
        tick();
        tx_push  = 1'b0;
    endtask

    task automatic pulses(input int n);
        shift_pulse = 1'b1;
        for (int i = 0; i < n; i++) tick();
        shift_pulse = 1'b0;
    endtask

    // Pop everything from RX and compare against the scoreboard, bounded by DEPTH+1 pops.
    task automatic drain_rx(input string tag);
        logic [31:0] want;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            if (!rx_empty) begin
                want = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD;
                check_eq(tag, rx_rdata, want);
                rx_pop = 1'b1;
                tick();
                rx_pop = 1'b0;
            end
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
        check_eq({tag, "_empty"}, rx_empty, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_tx_level"}, tx_level, 0);
        check_eq({tag, "_rx_level"}, rx_level, 0);
        check_eq({tag, "_tx_empty"}, tx_empty, 1);
        check_eq({tag, "_rx_empty"}, rx_empty, 1);
        check_eq({tag, "_fulls"}, {tx_full, rx_full}, 0);
        check_eq({tag, "_flags"}, {tx_ovf, rx_ovf, shift_unf}, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_bit_out"}, bit_out, 0);
        check_eq({tag, "_byte_done"}, byte_done, 0);
        check_eq({tag, "_rx_rdata"}, rx_rdata, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bytes [3];
        logic [7:0] cur;
        logic [2:0] lsb_pat;

        rst_n = 1'b0; tx_wdata = '0; tx_push = 0; rx_pop = 0; flush = 0; flag_clr = 0;
        shift_pulse = 0; shift_dir = 0; comm_drv = 0; loop_en = 0;
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic MSB-first loopback of 0xA5.
        loop_en = 1; shift_dir = 0;
        exp_q.push_back(8'hA5);
        push_byte(8'hA5);
        check_eq("a5_tx_level", tx_level, 1);
        check_eq("a5_busy_pre", busy, 0);
        tick();
        check_eq("a5_busy", busy, 1);
        check_eq("a5_tx_drained", tx_level, 0);
        cur = 8'hA5;
        shift_pulse = 1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("a5_bit%0d", i), bit_out, cur[7-i]);
            tick();
        end
        shift_pulse = 0;
        check_eq("a5_byte_done", byte_done, 1);
        check_eq("a5_rx_level", rx_level, 1);
        check_eq("a5_idle", busy, 0);
        tick();
        check_eq("a5_byte_done_off", byte_done, 0);
        drain_rx("a5_rx");

        // LSB-first receive with pattern 1,1,0,0,0,0,0,0.
        loop_en = 0; shift_dir = 1;
        exp_q.push_back(8'h03);
        push_byte(8'h00);
        tick();
        lsb_pat = 3'd2;
        shift_pulse = 1;
        for (int i = 0; i < 8; i++) begin
            comm_drv = (i < int'(lsb_pat));
            tick();
        end
        shift_pulse = 0; comm_drv = 0;
        drain_rx("lsb_rx");

        // Back-to-back: three bytes, 24 contiguous pulses, no idle gap.
        loop_en = 1; shift_dir = 0;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(bytes[k]);
            push_byte(bytes[k]);
        end
        shift_pulse = 1;
        for (int i = 0; i < 24; i++) begin
            cur = bytes[i / 8];
            check_eq($sformatf("b2b_busy%0d", i), busy, 1);
            check_eq($sformatf("b2b_bit%0d", i), bit_out, cur[7 - (i % 8)]);
            tick();
        end
        shift_pulse = 0;
        check_eq("b2b_idle", busy, 0);
        check_eq("b2b_rx_level", rx_level, 3);
        drain_rx("b2b_rx");

        // TX overflow: first push loads the shifter, four more fill TX, sixth is dropped.
        for (int k = 0; k < 5; k++) push_byte(8'h41 + 8'(k));
        check_eq("txovf_level4", tx_level, 4);
        check_eq("txovf_full", tx_full, 1);
        check_eq("txovf_flag_pre", tx_ovf, 0);
        push_byte(8'h46);
        check_eq("txovf_flag", tx_ovf, 1);
        check_eq("txovf_level", tx_level, 4);

        // RX overflow: four bytes fill RX, the fifth (0x45) is dropped.
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h41 + 8'(k));
        pulses(32);
        check_eq("rxovf_full", rx_full, 1);
        check_eq("rxovf_flag_pre", rx_ovf, 0);
        pulses(8);
        check_eq("rxovf_flag", rx_ovf, 1);
        check_eq("rxovf_level", rx_level, 4);
        check_eq("rxovf_head", rx_rdata, 8'h41);
        check_eq("rxovf_idle", busy, 0);

        // Pulse while idle.
        pulses(1);
        check_eq("unf_flag", shift_unf, 1);
        check_eq("unf_rx_level", rx_level, 4);

        // flag_clr together with a new underflow keeps shift_unf set.
        flag_clr = 1; shift_pulse = 1;
        tick();
        flag_clr = 0; shift_pulse = 0;
        check_eq("clr_race_unf", shift_unf, 1);
        check_eq("clr_race_ovf", {tx_ovf, rx_ovf}, 0);
        flag_clr = 1;
        tick();
        flag_clr = 0;
        check_eq("clr_flags", {tx_ovf, rx_ovf, shift_unf}, 0);

        // RX full, completion with simultaneous pop: push accepted, no overflow.
        exp_q.push_back(8'h5A);
        push_byte(8'h5A);
        tick();
        shift_pulse = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                check_eq("pop_race_head", rx_rdata, exp_q.pop_front());
                rx_pop = 1;
            end
            tick();
        end
        shift_pulse = 0; rx_pop = 0;
        check_eq("pop_race_level", rx_level, 4);
        check_eq("pop_race_ovf", rx_ovf, 0);
        drain_rx("pop_race_rx");

        // Flush mid-byte with a simultaneous push; 0x77 is received then flushed away.
        push_byte(8'h77);
        push_byte(8'h88);
        pulses(8);
        pulses(3);
        check_eq("flush_pre_rx", rx_level, 1);
        flush = 1; tx_wdata = 8'h99; tx_push = 1;
        tick();
        flush = 0; tx_push = 0;
        check_eq("flush_rx_level", rx_level, 0);
        check_eq("flush_tx_level", tx_level, 0);
        check_eq("flush_busy", busy, 0);
        check_eq("flush_bit_out", bit_out, 0);
        tick();
        check_eq("flush_no_load", busy, 0);

        // Asynchronous reset mid-byte, with a flag set beforehand.
        pulses(1);
        check_eq("rst_pre_unf", shift_unf, 1);
        push_byte(8'hC3);
        push_byte(8'h3C);
        pulses(3);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_busy", busy, 0);

        // Sanity after reset.
        exp_q.push_back(8'h5C);
        push_byte(8'h5C);
        tick();
        pulses(8);
        drain_rx("post_rst_rx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
